rv_writeback: RTL and testbench

- Writeback stage of the uRV pipeline, directly downstream of the execute stage.
- Consumes the execute-stage writeback bundle (rd, value, write, fun, load/store flags, data address) and the data-memory load return.
- Aligns and sign/zero-extends load data, then issues the single register-file write port.
- Stalls the pipeline while a load is outstanding; its registered outputs also serve as the decode-stage bypass source.

---
 rtl/rv_writeback_pkg.sv | 17 +
 rtl/rv_load_align.sv | 34 +++
 rtl/rv_writeback.sv | 132 +++++++++++++
 tb/tb_rv_writeback.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_writeback_pkg.sv
// rtl/rv_writeback_pkg.sv - load size codes and writeback FSM encodings for the uRV writeback stage
package rv_writeback_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam int WB_CNT_W = 16;

    typedef enum logic {
        WB_STATE_IDLE      = 1'b0,
        WB_STATE_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/rv_load_align.sv
// rtl/rv_load_align.sv - combinational load data lane select and sign/zero extension
module rv_load_align
    import rv_writeback_pkg::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  sel,
    input  logic [31:0] data,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (sel)
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            2'd3:    byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        // Halfword lanes only look at addr[1]; a misaligned addr[0] is simply dropped.
        half_sel = sel[1] ? data[31:16] : data[15:0];

        case (fun)
            LDST_B:  value = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: value = {24'd0, byte_sel};
            LDST_H:  value = {{16{half_sel[15]}}, half_sel};
            LDST_HU: value = {16'd0, half_sel};
            LDST_L:  value = data;
            default: value = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// rtl/rv_writeback.sv - uRV writeback stage: load wait/align and RF write port (option: RV_WB_LOAD_TIMEOUT_EN)
module rv_writeback
    import rv_writeback_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_stall_req_o,
    output logic        w_load_error_o
);

    if (LOAD_TIMEOUT < 1 || LOAD_TIMEOUT > 65535) begin : g_bad_load_timeout
        $error("rv_writeback: LOAD_TIMEOUT must be within 1..65535");
    end

    wb_state_e   state;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_fun;
    logic [1:0]  cap_sel;
    logic        waiting;
    logic [2:0]  al_fun;
    logic [1:0]  al_sel;
    logic [31:0] al_value;
    logic        unused_inputs;

    // Stores complete upstream; only the byte lane of the address matters here.
    assign unused_inputs = ^{x_store_i, x_dm_addr_i[31:2]};

    assign waiting = (state == WB_STATE_WAIT_LOAD);
    assign al_fun  = waiting ? cap_fun : x_fun_i;
    assign al_sel  = waiting ? cap_sel : x_dm_addr_i[1:0];

    rv_load_align u_load_align (
        .fun   (al_fun),
        .sel   (al_sel),
        .data  (dm_data_l_i),
        .value (al_value)
    );

    assign w_stall_req_o = rst_n_i & ~dm_load_done_i & (waiting | x_load_i);

`ifdef RV_WB_LOAD_TIMEOUT_EN
    logic [WB_CNT_W-1:0] wait_cnt;
    logic                load_error;
    logic                load_expired;

    // The issue cycle already stalled once, so the final WAIT_LOAD cycle is at cnt+2 == LOAD_TIMEOUT.
    assign load_expired   = (32'(wait_cnt) + 32'd2) >= LOAD_TIMEOUT;
    assign w_load_error_o = load_error;
`else
    assign w_load_error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= WB_STATE_IDLE;
            cap_rd        <= '0;
            cap_fun       <= '0;
            cap_sel       <= '0;
            rf_rd_o       <= '0;
            rf_rd_value_o <= '0;
            rf_rd_write_o <= 1'b0;
`ifdef RV_WB_LOAD_TIMEOUT_EN
            wait_cnt      <= '0;
            load_error    <= 1'b0;
`endif
        end else begin
            rf_rd_write_o <= 1'b0;
`ifdef RV_WB_LOAD_TIMEOUT_EN
            load_error    <= 1'b0;
`endif
            case (state)
                WB_STATE_IDLE: begin
                    if (x_load_i) begin
                        if (dm_load_done_i) begin
                            if (x_rd_i != 5'd0) begin
                                rf_rd_o       <= x_rd_i;
                                rf_rd_value_o <= al_value;
                                rf_rd_write_o <= 1'b1;
                            end
                        end else begin
                            cap_rd  <= x_rd_i;
                            cap_fun <= x_fun_i;
                            cap_sel <= x_dm_addr_i[1:0];
                            state   <= WB_STATE_WAIT_LOAD;
`ifdef RV_WB_LOAD_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end else if (x_rd_write_i && x_rd_i != 5'd0) begin
                        rf_rd_o       <= x_rd_i;
                        rf_rd_value_o <= x_rd_value_i;
                        rf_rd_write_o <= 1'b1;
                    end
                end
                WB_STATE_WAIT_LOAD: begin
                    if (dm_load_done_i) begin
                        if (cap_rd != 5'd0) begin
                            rf_rd_o       <= cap_rd;
                            rf_rd_value_o <= al_value;
                            rf_rd_write_o <= 1'b1;
                        end
                        state <= WB_STATE_IDLE;
                    end
`ifdef RV_WB_LOAD_TIMEOUT_EN
                    else if (load_expired) begin
                        load_error <= 1'b1;
                        state      <= WB_STATE_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= WB_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_writeback.sv
// tb/tb_rv_writeback.sv - directed table-driven bench for rv_writeback (timeout cases under RV_WB_LOAD_TIMEOUT_EN)
module tb_rv_writeback;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_L  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [2:0]  x_fun_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i;
    logic        x_rd_write_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic        w_stall_req_o;
    logic        w_load_error_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    rv_writeback #(.LOAD_TIMEOUT(4)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .x_fun_i        (x_fun_i),
        .x_load_i       (x_load_i),
        .x_store_i      (x_store_i),
        .x_rd_i         (x_rd_i),
        .x_rd_value_i   (x_rd_value_i),
        .x_rd_write_i   (x_rd_write_i),
        .x_dm_addr_i    (x_dm_addr_i),
        .dm_data_l_i    (dm_data_l_i),
        .dm_load_done_i (dm_load_done_i),
        .rf_rd_o        (rf_rd_o),
        .rf_rd_value_o  (rf_rd_value_o),
        .rf_rd_write_o  (rf_rd_write_o),
        .w_stall_req_o  (w_stall_req_o),
        .w_load_error_o (w_load_error_o)
    );

    typedef struct {
        logic        load;
        logic        store;
        logic        done;
        logic        rd_write;
        logic [2:0]  fun;
        logic [4:0]  rd;
        logic [31:0] rd_value;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_write;
        logic [4:0]  exp_rd;
        logic [31:0] exp_value;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        x_fun_i        = 3'b000;
        x_load_i       = 1'b0;
        x_store_i      = 1'b0;
        x_rd_i         = 5'd0;
        x_rd_value_i   = 32'd0;
        x_rd_write_i   = 1'b0;
        x_dm_addr_i    = 32'd0;
        dm_data_l_i    = 32'd0;
        dm_load_done_i = 1'b0;
    endtask

`ifdef RV_WB_LOAD_TIMEOUT_EN
    task automatic timeout_run(input logic with_done);
        int stall_cnt = 0;
        int err_cnt   = 0;
        int wr_cnt    = 0;
        logic err_at_end = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            idle_inputs();
            if (c == 0) begin
                x_load_i    = 1'b1;
                x_fun_i     = F_HU;
                x_rd_i      = 5'd23;
                x_dm_addr_i = 32'h0000_4002;
            end
            if (with_done && c == 3) begin
                dm_load_done_i = 1'b1;
                dm_data_l_i    = 32'hBEEF_0001;
            end
            #1;
            if (w_stall_req_o) stall_cnt++;
            @(posedge clk_i);
            #1;
            if (w_load_error_o) err_cnt++;
            if (rf_rd_write_o) wr_cnt++;
            if (c == 3) err_at_end = w_load_error_o;
        end
        if (with_done) begin
            check("to_done_stall_cycles", 32'(stall_cnt), 32'd3);
            check("to_done_errors", 32'(err_cnt), 32'd0);
            check("to_done_writes", 32'(wr_cnt), 32'd1);
            check("to_done_value", rf_rd_value_o, 32'h0000_BEEF);
        end else begin
            check("to_stall_cycles", 32'(stall_cnt), 32'd4);
            check("to_error_pulses", 32'(err_cnt), 32'd1);
            check("to_error_timing", 32'(err_at_end), 32'd1);
            check("to_no_write", 32'(wr_cnt), 32'd0);
        end
    endtask
`endif

    initial begin
        int stall_cnt;

        //          load store done wr   fun   rd     rd_value       addr           data           exp_wr rd  exp_value
        vecs[0]  = '{0, 0, 0, 1, F_B,  5'd5,  32'h1234_5678, 32'h0,         32'h0,         1, 5'd5,  32'h1234_5678};
        vecs[1]  = '{0, 0, 0, 0, F_B,  5'd5,  32'h0,         32'h0,         32'h0,         0, 5'd5,  32'h1234_5678};
        vecs[2]  = '{1, 0, 1, 0, F_B,  5'd7,  32'h0,         32'h0000_1003, 32'h80AA_BBCC, 1, 5'd7,  32'hFFFF_FF80};
        vecs[3]  = '{1, 0, 1, 0, F_BU, 5'd8,  32'h0,         32'h0000_1001, 32'h80AA_BBCC, 1, 5'd8,  32'h0000_00BB};
        vecs[4]  = '{1, 0, 1, 0, F_H,  5'd9,  32'h0,         32'h0000_2000, 32'h80AA_8BCC, 1, 5'd9,  32'hFFFF_8BCC};
        vecs[5]  = '{1, 0, 1, 0, F_H,  5'd10, 32'h0,         32'h0000_2003, 32'h80AA_BBCC, 1, 5'd10, 32'hFFFF_80AA};
        vecs[6]  = '{1, 0, 1, 0, F_L,  5'd11, 32'h0,         32'h0000_3001, 32'hDEAD_BEEF, 1, 5'd11, 32'hDEAD_BEEF};
        vecs[7]  = '{1, 0, 1, 0, 3'b011, 5'd12, 32'h0,       32'h0,         32'hFFFF_FFFF, 1, 5'd12, 32'h0000_0000};
        vecs[8]  = '{1, 0, 1, 1, F_B,  5'd13, 32'h1111_1111, 32'h0,         32'h0000_007F, 1, 5'd13, 32'h0000_007F};
        vecs[9]  = '{1, 0, 1, 0, F_L,  5'd0,  32'h0,         32'h0,         32'hCAFE_CAFE, 0, 5'd13, 32'h0000_007F};
        vecs[10] = '{0, 0, 0, 1, F_B,  5'd0,  32'hAAAA_AAAA, 32'h0,         32'h0,         0, 5'd13, 32'h0000_007F};
        vecs[11] = '{0, 1, 0, 0, F_L,  5'd14, 32'h5555_5555, 32'h0000_5000, 32'h0,         0, 5'd13, 32'h0000_007F};
        vecs[12] = '{0, 0, 1, 0, F_L,  5'd14, 32'h0,         32'h0,         32'h7777_7777, 0, 5'd13, 32'h0000_007F};
        vecs[13] = '{1, 0, 1, 0, F_BU, 5'd15, 32'h0,         32'h0000_0002, 32'h00FE_0000, 1, 5'd15, 32'h0000_00FE};
        vecs[14] = '{1, 0, 1, 0, F_HU, 5'd16, 32'h0,         32'h0000_0000, 32'h1234_8000, 1, 5'd16, 32'h0000_8000};

        // Reset state, with a load request present that must not raise stall.
        idle_inputs();
        rst_n_i  = 1'b0;
        x_load_i = 1'b1;
        #12;
        check("rst_stall", 32'(w_stall_req_o), 32'd0);
        check("rst_write", 32'(rf_rd_write_o), 32'd0);
        check("rst_rd", 32'(rf_rd_o), 32'd0);
        check("rst_value", rf_rd_value_o, 32'd0);
        check("rst_error", 32'(w_load_error_o), 32'd0);
        @(negedge clk_i);
        idle_inputs();
        rst_n_i = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            x_load_i       = vecs[i].load;
            x_store_i      = vecs[i].store;
            dm_load_done_i = vecs[i].done;
            x_rd_write_i   = vecs[i].rd_write;
            x_fun_i        = vecs[i].fun;
            x_rd_i         = vecs[i].rd;
            x_rd_value_i   = vecs[i].rd_value;
            x_dm_addr_i    = vecs[i].addr;
            dm_data_l_i    = vecs[i].data;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(w_stall_req_o), 32'd0);
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_write", i), 32'(rf_rd_write_o), 32'(vecs[i].exp_write));
            check($sformatf("vec%0d_rd", i), 32'(rf_rd_o), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_value", i), rf_rd_value_o, vecs[i].exp_value);
            check($sformatf("vec%0d_error", i), 32'(w_load_error_o), 32'd0);
        end

        // Outstanding HU load, done three cycles after issue; x_* noise during the wait must be ignored.
        @(negedge clk_i);
        idle_inputs();
        x_load_i    = 1'b1;
        x_fun_i     = F_HU;
        x_rd_i      = 5'd20;
        x_dm_addr_i = 32'h0000_2002;
        stall_cnt   = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (w_stall_req_o) stall_cnt++;
            @(posedge clk_i);
            #1;
            check($sformatf("wait%0d_no_write", c), 32'(rf_rd_write_o), 32'd0);
            @(negedge clk_i);
            x_load_i     = 1'b0;
            x_rd_write_i = 1'b1;
            x_rd_i       = 5'd21;
            x_rd_value_i = 32'h9999_9999;
            x_fun_i      = F_B;
            x_dm_addr_i  = 32'h0;
        end
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'hF00D_1234;
        #1;
        check("wait_stall_cycles", 32'(stall_cnt), 32'd3);
        check("wait_done_stall", 32'(w_stall_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("wait_write", 32'(rf_rd_write_o), 32'd1);
        check("wait_rd", 32'(rf_rd_o), 32'd20);
        check("wait_value", rf_rd_value_o, 32'h0000_F00D);
        @(negedge clk_i);
        idle_inputs();
        @(posedge clk_i);
        #1;
        check("wait_strobe_drop", 32'(rf_rd_write_o), 32'd0);

        // Reset pulse while a load is outstanding discards it.
        @(negedge clk_i);
        x_load_i = 1'b1;
        x_fun_i  = F_L;
        x_rd_i   = 5'd22;
        @(posedge clk_i);
        @(negedge clk_i);
        idle_inputs();
        #2;
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_rd", 32'(rf_rd_o), 32'd0);
        check("mid_rst_value", rf_rd_value_o, 32'd0);
        check("mid_rst_stall", 32'(w_stall_req_o), 32'd0);
        @(negedge clk_i);
        rst_n_i        = 1'b1;
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h1357_9BDF;
        #1;
        check("post_rst_stall", 32'(w_stall_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("post_rst_write", 32'(rf_rd_write_o), 32'd0);
        check("post_rst_value", rf_rd_value_o, 32'd0);
        @(negedge clk_i);
        idle_inputs();

`ifdef RV_WB_LOAD_TIMEOUT_EN
        timeout_run(1'b0);
        timeout_run(1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
